debug_uart_frame_tx: RTL and testbench
======================================

DEBUG_UART_FRAME_TX -- requirements
Module: debug_uart_frame_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, giving the clk_uart cycles per UART bit (legal range 2..4095).
REQ-002 SHALL have parameter HEADER_BYTE, default 8'hA5, giving the frame start marker.
REQ-003 SHALL have port clk_uart, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_tx_start, input, 1 bit: request to send one debug frame; sampled only in IDLE.
REQ-006 SHALL have port statedeb_main, input, 8 bits: debug state byte 0.
REQ-007 SHALL have port statedeb_can, input, 8 bits: debug state byte 1.
REQ-008 SHALL have port statedb_can_mux, input, 8 bits: debug state byte 2.
REQ-009 SHALL have port statedeb_osc_trim, input, 8 bits: debug state byte 3.
REQ-010 SHALL have port statedeb_elink_tra, input, 8 bits: debug state byte 4.
REQ-011 SHALL have port statedeb_elink_rec, input, 8 bits: debug state byte 5.
REQ-012 SHALL have port statedeb_spi, input, 8 bits: debug state byte 6.
REQ-013 SHALL have port out_tx_serial, output, 1 bit: UART line; idles high.
REQ-014 SHALL have port out_tx_active, output, 1 bit: high from frame start to the end of the last stop bit.
REQ-015 SHALL have port out_tx_done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-016 SHALL send 8N1 UART bytes, LSB first: start bit 0, 8 data bits, stop bit 1, each bit lasting exactly CLKS_PER_BIT cycles.
REQ-017 SHALL send the frame in this order: HEADER_BYTE, then state bytes 0..6, then an optional checksum (REQ-030).
REQ-018 SHALL register all seven state bytes in the cycle in_tx_start is accepted; input changes during the frame do not affect it.
REQ-019 SHALL use the FSM states IDLE, START, DATA, STOP and DONE.
REQ-020 FSM transitions SHALL be: IDLE->START on in_tx_start; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bits; STOP->START if bytes remain, else STOP->DONE; DONE->IDLE after one cycle.
REQ-021 SHALL drive out_tx_serial low in the cycle after in_tx_start is sampled high, giving a start latency of 1 cycle.
REQ-022 SHALL send the next byte's start bit in the cycle right after the previous stop bit ends, with no idle gap inside a frame.
REQ-023 SHALL assert out_tx_done for exactly one cycle, in the DONE state; out_tx_active is low in that cycle.
REQ-024 SHALL ignore in_tx_start whenever the FSM is not in IDLE; a request in the DONE cycle is dropped.
REQ-025 SHALL accept in_tx_start held high continuously as back-to-back frames separated only by the DONE and IDLE cycles.
REQ-026 SHALL use a baud counter of width $clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1 and wraps; a 3-bit bit index and a 4-bit byte index, with no overflow reachable.

Reset
REQ-027 While rst is high, the block SHALL hold out_tx_serial=1, out_tx_active=0, out_tx_done=0, state=IDLE, all counters=0 and the snapshot and checksum registers=0.
REQ-028 A reset asserted mid-frame SHALL abort the frame; the line is high in the cycle after rst is sampled, and no out_tx_done pulse follows.
REQ-029 If rst and in_tx_start are high in the same cycle, rst SHALL win and the request is discarded.

Configuration
REQ-030 With macro DEBUG_UART_CHECKSUM_EN defined, the block SHALL append a ninth byte equal to the XOR of the header and the 7 state bytes, accumulated as bytes are loaded.
REQ-031 Without DEBUG_UART_CHECKSUM_EN, the frame SHALL be 8 bytes, STOP->DONE SHALL follow byte 7, and no checksum logic SHALL be synthesised.

Verification
REQ-032 The bench SHALL drive CLKS_PER_BIT=87, state bytes 0A,0B,0C,0D,0E,0F,1A, and a 1-cycle in_tx_start with checksum enabled, and SHALL see A5,0A,0B,0C,0D,0E,0F,1A,BE on the serial line, out_tx_active for 7830 cycles, then a single out_tx_done.
REQ-033 The bench SHALL repeat the REQ-032 stimulus with the macro undefined and SHALL see 8 bytes with no BE byte, and out_tx_done 6960 cycles after the start bit.
REQ-034 The bench SHALL change statedeb_main to 0x55 and pulse in_tx_start during byte 3, and SHALL see the frame unchanged and no second frame.
REQ-035 The bench SHALL assert rst for 1 cycle during byte 4, and SHALL see the line high in the next cycle, no out_tx_done, and a fresh full frame on the next start.
REQ-036 The bench SHALL hold in_tx_start high for 3 frames, and SHALL see the start bits of consecutive frames 2 cycles after each done pulse, each frame decoding correctly in a loopback receiver.

Source files
------------

// File: rtl/debug_uart_frame_tx.sv
// Debug frame transmitter: sends HEADER_BYTE and seven snapshotted state bytes as 8N1 UART.
// Define DEBUG_UART_CHECKSUM_EN to append the XOR of all preceding frame bytes.
//
// state | meaning
// IDLE  | line high, waiting for in_tx_start
// START | start bit (line low) of the current byte
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high); chains to next START or to DONE
// DONE  | one-cycle completion pulse, then back to IDLE
module debug_uart_frame_tx #(
    parameter int         CLKS_PER_BIT = 87,
    parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
    input  logic       clk_uart,
    input  logic       rst,
    input  logic       in_tx_start,
    input  logic [7:0] statedeb_main,
    input  logic [7:0] statedeb_can,
    input  logic [7:0] statedb_can_mux,
    input  logic [7:0] statedeb_osc_trim,
    input  logic [7:0] statedeb_elink_tra,
    input  logic [7:0] statedeb_elink_rec,
    input  logic [7:0] statedeb_spi,
    output logic       out_tx_serial,
    output logic       out_tx_active,
    output logic       out_tx_done
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef DEBUG_UART_CHECKSUM_EN
    localparam logic [3:0]     LAST_BYTE = 4'd8;
`else
    localparam logic [3:0]     LAST_BYTE = 4'd7;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [3:0]      r_byte_idx;
    logic [6:0][7:0] r_snap;
`ifdef DEBUG_UART_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif
    logic [7:0]      w_cur_byte;
    logic            w_baud_tc;
    logic            w_accept;
    logic            w_last_byte;

    assign w_baud_tc   = (r_baud_cnt == BAUD_LAST);
    assign w_accept    = (r_state == IDLE) && in_tx_start;
    assign w_last_byte = (r_byte_idx == LAST_BYTE);

    // Byte index 0 is the header, 1..7 the snapshot, 8 the optional checksum.
    always_comb begin
        w_cur_byte = 8'hFF;
        case (r_byte_idx)
            4'd0: w_cur_byte = HEADER_BYTE;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                  w_cur_byte = r_snap[r_byte_idx[2:0] - 3'd1];
`ifdef DEBUG_UART_CHECKSUM_EN
            4'd8: w_cur_byte = r_csum;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_uart) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (in_tx_start) w_state_nxt = START;
            START: if (w_baud_tc) w_state_nxt = DATA;
            DATA:  if (w_baud_tc && (r_bit_idx == 3'd7)) w_state_nxt = STOP;
            STOP:  if (w_baud_tc) w_state_nxt = w_last_byte ? DONE : START;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_uart) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_snap     <= '0;
`ifdef DEBUG_UART_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_snap     <= {statedeb_spi, statedeb_elink_rec, statedeb_elink_tra,
                                       statedeb_osc_trim, statedb_can_mux, statedeb_can,
                                       statedeb_main};
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_byte_idx <= '0;
`ifdef DEBUG_UART_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                START, DATA, STOP: begin
                    r_baud_cnt <= w_baud_tc ? '0 : r_baud_cnt + 1'b1;
                    if ((r_state == DATA) && w_baud_tc) begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    // Checksum folds in each byte as it leaves, so it is ready when byte 8 loads.
                    if ((r_state == STOP) && w_baud_tc && !w_last_byte) begin
                        r_byte_idx <= r_byte_idx + 4'd1;
`ifdef DEBUG_UART_CHECKSUM_EN
                        r_csum     <= r_csum ^ w_cur_byte;
`endif
                    end
                end
                default: begin
                    r_baud_cnt <= '0;
                    r_bit_idx  <= '0;
                    r_byte_idx <= '0;
                end
            endcase
        end
    end

    always_comb begin
        out_tx_serial = 1'b1;
        case (r_state)
            START:   out_tx_serial = 1'b0;
            DATA:    out_tx_serial = w_cur_byte[r_bit_idx];
            default: ;
        endcase
    end

    assign out_tx_active = (r_state == START) || (r_state == DATA) || (r_state == STOP);
    assign out_tx_done   = (r_state == DONE);

endmodule

// File: tb/tb_debug_uart_frame_tx.sv
// Bench for debug_uart_frame_tx: loopback UART receiver plus a frame-list/XOR reference model.
// Expectations follow DEBUG_UART_CHECKSUM_EN as defined for the build.
module tb_debug_uart_frame_tx;

    localparam int         CPB      = 87;
    localparam logic [7:0] HDR      = 8'hA5;
`ifdef DEBUG_UART_CHECKSUM_EN
    localparam int         FLEN     = 9;
`else
    localparam int         FLEN     = 8;
`endif
    localparam int         BYTE_CYC  = 10 * CPB;
    localparam int         FRAME_CYC = FLEN * BYTE_CYC;

    logic       clk_uart = 1'b0;
    logic       rst;
    logic       in_tx_start;
    logic [7:0] statedeb_main, statedeb_can, statedb_can_mux, statedeb_osc_trim;
    logic [7:0] statedeb_elink_tra, statedeb_elink_rec, statedeb_spi;
    logic       out_tx_serial, out_tx_active, out_tx_done;

    debug_uart_frame_tx #(.CLKS_PER_BIT(CPB), .HEADER_BYTE(HDR)) dut (
        .clk_uart          (clk_uart),
        .rst               (rst),
        .in_tx_start       (in_tx_start),
        .statedeb_main     (statedeb_main),
        .statedeb_can      (statedeb_can),
        .statedb_can_mux   (statedb_can_mux),
        .statedeb_osc_trim (statedeb_osc_trim),
        .statedeb_elink_tra(statedeb_elink_tra),
        .statedeb_elink_rec(statedeb_elink_rec),
        .statedeb_spi      (statedeb_spi),
        .out_tx_serial     (out_tx_serial),
        .out_tx_active     (out_tx_active),
        .out_tx_done       (out_tx_done)
    );

    always #5 clk_uart = ~clk_uart;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         act_cnt = 0;
    int         done_act = 0;
    int         stop_err = 0;
    logic [7:0] st [7];
    logic [7:0] exp_q [$];
    logic [7:0] rx_q [$];
    int         rx_t [$];
    int         done_q [$];

    always @(posedge clk_uart) cyc <= cyc + 1;

    always @(negedge clk_uart) begin
        if (out_tx_active === 1'b1) act_cnt <= act_cnt + 1;
        if (out_tx_done === 1'b1) begin
            done_q.push_back(cyc);
            if (out_tx_active !== 1'b0) done_act <= done_act + 1;
        end
    end

    // Loopback receiver: find the start edge, sample each bit at its centre.
    initial begin : rx_mon
        logic [7:0] b;
        int         t0;
        forever begin
            @(negedge clk_uart);
            if (out_tx_serial === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk_uart);
                if (out_tx_serial === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk_uart);
                        b[i] = out_tx_serial;
                    end
                    repeat (CPB) @(negedge clk_uart);
                    if (out_tx_serial !== 1'b1) stop_err++;
                    rx_q.push_back(b);
                    rx_t.push_back(t0);
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_state();
        for (int i = 0; i < 7; i++) st[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic drive_state();
        statedeb_main      = st[0];
        statedeb_can       = st[1];
        statedb_can_mux    = st[2];
        statedeb_osc_trim  = st[3];
        statedeb_elink_tra = st[4];
        statedeb_elink_rec = st[5];
        statedeb_spi       = st[6];
    endtask

    // Reference frame: header, the seven bytes, then (optionally) their running XOR.
    task automatic build_model();
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(HDR);
        x = HDR;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(st[i]);
            x ^= st[i];
        end
`ifdef DEBUG_UART_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic clear_mon();
        rx_q.delete();
        rx_t.delete();
        done_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk_uart);
        in_tx_start = 1'b1;
        @(negedge clk_uart);
        in_tx_start = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(negedge clk_uart);
            k++;
        end
        check({tag, "_done_timeout"}, 32'(done_q.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int base);
        check({tag, "_have_bytes"}, 32'(rx_q.size() >= base + FLEN), 32'd1);
        for (int i = 0; i < FLEN; i++) begin
            if (base + i < rx_q.size()) begin
                check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[base + i]), 32'(exp_q[i]));
                if (i > 0)
                    check($sformatf("%s_gap%0d", tag, i),
                          32'(rx_t[base + i] - rx_t[base + i - 1]), 32'(BYTE_CYC));
            end
        end
    endtask

    initial begin : main
        int a0;
        int nd;
        int k;
        rst = 1'b1;
        in_tx_start = 1'b0;
        for (int i = 0; i < 7; i++) st[i] = 8'h00;
        drive_state();
        repeat (3) @(negedge clk_uart);
        check("rst_serial", 32'(out_tx_serial), 32'd1);
        check("rst_active", 32'(out_tx_active), 32'd0);
        check("rst_done", 32'(out_tx_done), 32'd0);
        rst = 1'b0;
        @(negedge clk_uart);

        // Reset and request in the same cycle: reset wins.
        rst = 1'b1;
        in_tx_start = 1'b1;
        @(negedge clk_uart);
        rst = 1'b0;
        in_tx_start = 1'b0;
        repeat (3) @(negedge clk_uart);
        check("rst_vs_start_serial", 32'(out_tx_serial), 32'd1);
        check("rst_vs_start_active", 32'(out_tx_active), 32'd0);
        repeat (20) @(negedge clk_uart);
        check("rst_vs_start_no_frame", 32'(rx_q.size()), 32'd0);

        // Fixed frame 0A..1A, single-cycle request.
        st[0] = 8'h0A; st[1] = 8'h0B; st[2] = 8'h0C; st[3] = 8'h0D;
        st[4] = 8'h0E; st[5] = 8'h0F; st[6] = 8'h1A;
        drive_state();
        build_model();
        clear_mon();
        a0 = act_cnt;
        in_tx_start = 1'b1;
        check("s1_line_before", 32'(out_tx_serial), 32'd1);
        @(negedge clk_uart);
        in_tx_start = 1'b0;
        check("s1_start_latency", 32'(out_tx_serial), 32'd0);
        check("s1_active_on", 32'(out_tx_active), 32'd1);
        wait_dones(1, FRAME_CYC + 100, "s1");
        repeat (50) @(negedge clk_uart);
        check_frame("s1", 0);
        check("s1_nbytes", 32'(rx_q.size()), 32'(FLEN));
        if (rx_q.size() == FLEN)
            check("s1_last_byte", 32'(rx_q[FLEN - 1]), (FLEN == 9) ? 32'hBE : 32'h1A);
        check("s1_active_cycles", 32'(act_cnt - a0), 32'(FRAME_CYC));
        check("s1_ndone", 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0 && rx_t.size() > 0)
            check("s1_done_latency", 32'(done_q[0] - rx_t[0]), 32'(FRAME_CYC));
        check("s1_done_vs_active", 32'(done_act), 32'd0);

        // Input changes and a stray request mid-frame must not disturb it.
        clear_mon();
        rand_state();
        drive_state();
        build_model();
        pulse_start();
        k = 0;
        while (rx_q.size() < 3 && k < 4 * BYTE_CYC) begin
            @(negedge clk_uart);
            k++;
        end
        repeat (3 * CPB) @(negedge clk_uart);
        statedeb_main = 8'h55;
        statedeb_spi  = ~st[6];
        pulse_start();
        wait_dones(1, FRAME_CYC + 100, "s2");
        repeat (1000) @(negedge clk_uart);
        check_frame("s2", 0);
        check("s2_nbytes", 32'(rx_q.size()), 32'(FLEN));
        check("s2_ndone", 32'(done_q.size()), 32'd1);

        // Reset during byte 4 aborts the frame.
        clear_mon();
        rand_state();
        drive_state();
        build_model();
        pulse_start();
        k = 0;
        while (rx_q.size() < 4 && k < 5 * BYTE_CYC) begin
            @(negedge clk_uart);
            k++;
        end
        repeat (400) @(negedge clk_uart);
        check("s3_active_before_rst", 32'(out_tx_active), 32'd1);
        rst = 1'b1;
        @(negedge clk_uart);
        rst = 1'b0;
        check("s3_line_after_rst", 32'(out_tx_serial), 32'd1);
        check("s3_active_after_rst", 32'(out_tx_active), 32'd0);
        repeat (1100) @(negedge clk_uart);
        check("s3_no_done", 32'(done_q.size()), 32'd0);
        check("s3_line_idle", 32'(out_tx_serial), 32'd1);
        clear_mon();
        rand_state();
        drive_state();
        build_model();
        pulse_start();
        wait_dones(1, FRAME_CYC + 100, "s3b");
        repeat (50) @(negedge clk_uart);
        check_frame("s3b", 0);
        check("s3b_nbytes", 32'(rx_q.size()), 32'(FLEN));

        // Request held high: three back-to-back frames.
        clear_mon();
        rand_state();
        drive_state();
        build_model();
        @(negedge clk_uart);
        in_tx_start = 1'b1;
        nd = 0;
        k = 0;
        while (nd < 3 && k < 4 * FRAME_CYC) begin
            @(negedge clk_uart);
            k++;
            if (out_tx_done === 1'b1) begin
                nd++;
                if (nd == 3) in_tx_start = 1'b0;
            end
        end
        check("s4_three_dones", 32'(nd), 32'd3);
        repeat (1000) @(negedge clk_uart);
        check("s4_ndone", 32'(done_q.size()), 32'd3);
        check("s4_nbytes", 32'(rx_q.size()), 32'(3 * FLEN));
        for (int f = 0; f < 3; f++) check_frame($sformatf("s4_f%0d", f), f * FLEN);
        for (int f = 0; f < 2; f++) begin
            if (done_q.size() > f && rx_t.size() > (f + 1) * FLEN)
                check($sformatf("s4_restart%0d", f),
                      32'(rx_t[(f + 1) * FLEN] - done_q[f]), 32'd2);
        end
        check("stop_bits", 32'(stop_err), 32'd0);
        check("done_vs_active", 32'(done_act), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
